// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch side.
package imem_pkg;

    // Encoding that terminates every program image.
    localparam logic [31:0] HALT_WORD = 32'hB422_1820;

    // Instructions are fixed at 32 bits, delivered as four bytes, MSB first.
    localparam int BYTES_PER_WORD = 4;

    // Word index <-> byte address shift; the fetch side indexes with addr >> 2.
    localparam int WORD_ADDR_SHIFT = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_e;

    // Word index to the byte address presented on the memory write port.
    function automatic logic [31:0] word_to_byte_addr(input logic [31:0] idx);
        return idx << WORD_ADDR_SHIFT;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and memory write port of the program loader.
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    // Loader side: consumes bytes, drives the memory write port.
    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, wr_en, wr_addr, wr_data
    );

    // Host/memory side: supplies bytes, observes writes.
    modport master (
        output rx_valid, rx_data,
        input  rx_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/byte_packer.sv
// Packs a byte stream big-endian into 32-bit words; first byte lands in [31:24].
module byte_packer
    import imem_pkg::*;
#(
    parameter int LW = $clog2(BYTES_PER_WORD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          strobe_i,
    input  logic [7:0]    byte_i,
    output logic [LW-1:0] lane_o,
    output logic [31:0]   word_o,
    output logic          word_full_o
);

    logic [LW-1:0] lane_q, lane_d;
    logic [31:0]   word_q, word_d;
    logic          take;

    // A clear wins over a simultaneous byte so a restart never keeps a stale lane.
    assign take = strobe_i && !clear_i;

    // Each lane owns one byte of the word; only the addressed lane is replaced.
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
        assign word_d[31-8*gi -: 8] = (take && (lane_q == LW'(gi))) ? byte_i
                                                                      : word_q[31-8*gi -: 8];
    end

    // Lane counter advances per byte and wraps after the last lane.
    always_comb begin
        lane_d = lane_q;
        if (clear_i) begin
            lane_d = '0;
        end else if (strobe_i) begin
            lane_d = lane_q + 1'b1;
        end
    end

    // Lane and partial-word storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_q <= '0;
            word_q <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

    // word_o includes this cycle's byte so the completed word is visible on the 4th strobe.
    assign lane_o      = lane_q;
    assign word_o      = word_d;
    assign word_full_o = take && (lane_q == LW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a byte-streamed program into instruction memory and holds the CPU
// in reset until a HALT word has been stored.
module imem_loader #(
    parameter int          SIZE       = 64,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] HALT_WORD  = imem_pkg::HALT_WORD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    imem_loader_if.slave          bus,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  overflow_err,
    output logic [$clog2(SIZE):0] word_count
);
    import imem_pkg::*;

    localparam int            CW        = $clog2(SIZE) + 1;
    localparam logic [CW-1:0] SIZE_C    = CW'(SIZE);
    localparam logic [1:0]    LAST_LANE = 2'(BYTES_PER_WORD - 1);

    loader_state_e         state_q, state_d;
    logic [CW-1:0]         word_count_q, word_count_d;
    logic [31:0]           wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic        rx_ready_c;
    logic        wr_en_c;
    logic        pk_clear;
    logic        byte_stb;
    logic        last_byte;
    logic [1:0]  pk_lane;
    logic [31:0] pk_word;
    logic        pk_full;

    assign byte_stb  = bus.rx_valid && rx_ready_c;
    assign last_byte = byte_stb && (pk_lane == LAST_LANE);

    byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (pk_clear),
        .strobe_i    (byte_stb),
        .byte_i      (bus.rx_data),
        .lane_o      (pk_lane),
        .word_o      (pk_word),
        .word_full_o (pk_full)
    );

    // Next-state and handshake decode; start is honoured only from IDLE/DONE/ERROR.
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        pk_clear     = 1'b0;
        rx_ready_c   = 1'b0;
        wr_en_c      = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    word_count_d = '0;
                    pk_clear     = 1'b1;
                end
            end
            ST_LOAD: begin
                rx_ready_c = 1'b1;
                if (last_byte) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wr_en_c      = 1'b1;
                word_count_d = word_count_q + 1'b1;
                // HALT is tested first so a HALT in the last slot still completes.
                if (wr_data_q == HALT_WORD) begin
                    state_d = ST_DONE;
                end else if (word_count_d == SIZE_C) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write-port address/data are captured once per completed word and then held.
    always_comb begin
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (pk_full) begin
            wr_addr_d = word_to_byte_addr(32'(word_count_q));
            wr_data_d = pk_word;
        end
    end

    // State, word counter and write-port registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            word_count_q <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign bus.rx_ready = rx_ready_c;
    assign bus.wr_en    = wr_en_c;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;

    // The CPU runs only once a complete program (ending in HALT) is in memory.
    assign cpu_hold     = (state_q != ST_DONE);
    assign done         = (state_q == ST_DONE);
    assign overflow_err = (state_q == ST_ERROR);
    assign word_count   = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 4-word memory so overflow is reachable.
module tb_imem_loader;

    localparam int SIZE = 4;
    localparam int CW   = $clog2(SIZE) + 1;

    logic          clk;
    logic          reset;
    logic          start;
    logic          cpu_hold;
    logic          done;
    logic          overflow_err;
    logic [CW-1:0] word_count;

    imem_loader_if bus ();

    imem_loader #(
        .SIZE       (SIZE),
        .DATA_WIDTH (32),
        .HALT_WORD  (32'hB422_1820)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .overflow_err (overflow_err),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Observed traffic, sampled on the active edge (pre-update values).
    int          mon_bytes  = 0;
    int          mon_writes = 0;
    logic [31:0] mon_last_addr = '0;
    logic [31:0] mon_last_data = '0;

    typedef struct {
        bit          do_start;
        int          gap;
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp_data;
        logic [31:0] exp_addr;
        logic        exp_done;
        logic        exp_err;
        logic        exp_hold;
        int          exp_count;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input bit s, input int g,
                                input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3,
                                input logic [31:0] d, input logic [31:0] a,
                                input logic dn, input logic er, input logic hd,
                                input int c);
        vec_t v;
        v.do_start = s;  v.gap = g;
        v.b0 = b0; v.b1 = b1; v.b2 = b2; v.b3 = b3;
        v.exp_data = d;  v.exp_addr = a;
        v.exp_done = dn; v.exp_err = er; v.exp_hold = hd; v.exp_count = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // A write must only happen once all four bytes of that word were accepted.
    always @(posedge clk) begin
        if (bus.rx_valid && bus.rx_ready) mon_bytes++;
        if (bus.wr_en) begin
            mon_writes++;
            mon_last_addr = bus.wr_addr;
            mon_last_data = bus.wr_data;
            checks++;
            if (mon_bytes != int'((bus.wr_addr >> 2) + 1) * 4) begin
                errors++;
                $display("FAIL write_timing: write at %h after %0d bytes, expected %0d",
                         bus.wr_addr, mon_bytes, int'((bus.wr_addr >> 2) + 1) * 4);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
        mon_bytes = 0;
    endtask

    // Offer one byte after `gap` idle cycles; wait (bounded) for it to be taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bus.rx_valid = 1'b0;
        repeat (gap) tick();
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        n = 0;
        while (!bus.rx_ready && n < 10) begin
            tick();
            n++;
        end
        chk("rx_handshake", {31'b0, bus.rx_ready}, 32'd1);
        if (bus.rx_ready) tick();
        bus.rx_valid = 1'b0;
    endtask

    // Send a word's bytes; returns after the WRITE cycle has completed.
    task automatic send_bytes(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input int gap, input bit chk_hold);
        logic [7:0] bs[4];
        bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
        for (int k = 0; k < 4; k++) begin
            send_byte(bs[k], gap);
            if (chk_hold) chk("hold_during_reload", {31'b0, cpu_hold}, 32'd1);
        end
        chk("wr_en_in_write", {31'b0, bus.wr_en}, 32'd1);
        tick();
    endtask

    task automatic apply_vec(input int i);
        int w0;
        vec_t v;
        v = vecs[i];
        if (v.do_start) do_start();
        w0 = mon_writes;
        send_bytes(v.b0, v.b1, v.b2, v.b3, v.gap, 1'b0);
        chk("write_count",  mon_writes, w0 + 1);
        chk("write_addr",   mon_last_addr, v.exp_addr);
        chk("write_data",   mon_last_data, v.exp_data);
        chk("wr_en_low",    {31'b0, bus.wr_en}, 32'd0);
        chk("addr_held",    bus.wr_addr, v.exp_addr);
        chk("data_held",    bus.wr_data, v.exp_data);
        chk("done",         {31'b0, done}, {31'b0, v.exp_done});
        chk("overflow_err", {31'b0, overflow_err}, {31'b0, v.exp_err});
        chk("cpu_hold",     {31'b0, cpu_hold}, {31'b0, v.exp_hold});
        chk("word_count",   32'(word_count), v.exp_count);
        chk("rx_ready",     {31'b0, bus.rx_ready}, {31'b0, !(v.exp_done || v.exp_err)});
        $display("vec %0d: wrote %h at %h, done=%0b err=%0b hold=%0b count=%0d",
                 i, mon_last_data, mon_last_addr, done, overflow_err, cpu_hold, word_count);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int w0;
        clk = 1'b0; reset = 1'b0; start = 1'b0;
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00;

        // 3-word program back-to-back, the same with gaps, overflow, HALT in last slot.
        vecs[0]  = mk(1, 0, 8'h8C, 8'h01, 8'h00, 8'h00, 32'h8C010000, 32'd0,  0, 0, 1, 1);
        vecs[1]  = mk(0, 0, 8'h34, 8'h02, 8'h00, 8'h04, 32'h34020004, 32'd4,  0, 0, 1, 2);
        vecs[2]  = mk(0, 0, 8'hB4, 8'h22, 8'h18, 8'h20, 32'hB4221820, 32'd8,  1, 0, 0, 3);
        vecs[3]  = mk(1, 3, 8'h8C, 8'h01, 8'h00, 8'h00, 32'h8C010000, 32'd0,  0, 0, 1, 1);
        vecs[4]  = mk(0, 3, 8'h34, 8'h02, 8'h00, 8'h04, 32'h34020004, 32'd4,  0, 0, 1, 2);
        vecs[5]  = mk(0, 3, 8'hB4, 8'h22, 8'h18, 8'h20, 32'hB4221820, 32'd8,  1, 0, 0, 3);
        vecs[6]  = mk(1, 0, 8'h00, 8'h00, 8'h00, 8'h20, 32'h00000020, 32'd0,  0, 0, 1, 1);
        vecs[7]  = mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h20, 32'h00000020, 32'd4,  0, 0, 1, 2);
        vecs[8]  = mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h20, 32'h00000020, 32'd8,  0, 0, 1, 3);
        vecs[9]  = mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h20, 32'h00000020, 32'd12, 0, 1, 1, 4);
        vecs[10] = mk(1, 0, 8'h00, 8'h00, 8'h00, 8'h20, 32'h00000020, 32'd0,  0, 0, 1, 1);
        vecs[11] = mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h20, 32'h00000020, 32'd4,  0, 0, 1, 2);
        vecs[12] = mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h20, 32'h00000020, 32'd8,  0, 0, 1, 3);
        vecs[13] = mk(0, 0, 8'hB4, 8'h22, 8'h18, 8'h20, 32'hB4221820, 32'd12, 1, 0, 0, 4);

        tick(); tick();

        // Reset values while reset is held low.
        chk("rst_rx_ready",   {31'b0, bus.rx_ready}, 32'd0);
        chk("rst_wr_en",      {31'b0, bus.wr_en}, 32'd0);
        chk("rst_wr_addr",    bus.wr_addr, 32'd0);
        chk("rst_wr_data",    bus.wr_data, 32'd0);
        chk("rst_cpu_hold",   {31'b0, cpu_hold}, 32'd1);
        chk("rst_done",       {31'b0, done}, 32'd0);
        chk("rst_overflow",   {31'b0, overflow_err}, 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        $display("reset: hold=%0b done=%0b count=%0d", cpu_hold, done, word_count);
        reset = 1'b1;
        tick();

        // IDLE must not take bytes even when the source offers them.
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hAA;
        for (int k = 0; k < 3; k++) begin
            chk("idle_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
            tick();
        end
        bus.rx_valid = 1'b0;
        chk("idle_no_write", mon_writes, 0);
        chk("idle_no_bytes", mon_bytes, 0);
        $display("idle: rx_valid ignored, bytes=%0d writes=%0d", mon_bytes, mon_writes);

        for (int i = 0; i < 14; i++) apply_vec(i);

        // Restart from DONE: 2-word program, CPU held throughout the reload.
        do_start();
        chk("reload_hold_start", {31'b0, cpu_hold}, 32'd1);
        chk("reload_done_clr",   {31'b0, done}, 32'd0);
        send_bytes(8'h00, 8'h00, 8'h00, 8'h20, 0, 1'b1);
        chk("reload_hold_w0",    {31'b0, cpu_hold}, 32'd1);
        chk("reload_addr0",      mon_last_addr, 32'd0);
        chk("reload_data0",      mon_last_data, 32'h00000020);
        send_bytes(8'hB4, 8'h22, 8'h18, 8'h20, 0, 1'b1);
        chk("reload_addr1",      mon_last_addr, 32'd4);
        chk("reload_data1",      mon_last_data, 32'hB4221820);
        chk("reload_done",       {31'b0, done}, 32'd1);
        chk("reload_release",    {31'b0, cpu_hold}, 32'd0);
        chk("reload_count",      32'(word_count), 32'd2);
        $display("reload: last %h at %h, count=%0d", mon_last_data, mon_last_addr, word_count);

        // start pulse in the middle of a word is ignored.
        do_start();
        send_byte(8'h8C, 0);
        send_byte(8'h01, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("midload_rx_ready", {31'b0, bus.rx_ready}, 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("midload_wr_en",    {31'b0, bus.wr_en}, 32'd1);
        chk("midload_data",     bus.wr_data, 32'h8C010000);
        chk("midload_addr",     bus.wr_addr, 32'd0);
        tick();
        chk("midload_count",    32'(word_count), 32'd1);
        $display("midload start: wrote %h at %h, count=%0d", mon_last_data, mon_last_addr, word_count);

        // Asynchronous reset mid-word drops the partial word without writing.
        send_byte(8'h8C, 0);
        send_byte(8'h01, 0);
        w0 = mon_writes;
        reset = 1'b0;
        #1;
        chk("midrst_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
        chk("midrst_wr_en",    {31'b0, bus.wr_en}, 32'd0);
        chk("midrst_hold",     {31'b0, cpu_hold}, 32'd1);
        chk("midrst_count",    32'(word_count), 32'd0);
        tick(); tick();
        chk("midrst_no_write", mon_writes, w0);
        reset = 1'b1;
        mon_bytes = 0;
        tick();
        chk("midrst_idle_ready", {31'b0, bus.rx_ready}, 32'd0);
        do_start();
        send_bytes(8'h8C, 8'h01, 8'h00, 8'h00, 0, 1'b0);
        chk("postrst_writes", mon_writes, w0 + 1);
        chk("postrst_addr",   mon_last_addr, 32'd0);
        chk("postrst_data",   mon_last_data, 32'h8C010000);
        chk("postrst_count",  32'(word_count), 32'd1);
        $display("after reset: wrote %h at %h, count=%0d", mon_last_data, mon_last_addr, word_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction memory.
- Accepts a program as a byte stream over a valid/ready handshake and packs it big-endian into 32-bit words.
- Drives the instruction memory's word-aligned byte-address write port and holds the CPU in reset until a HALT word has been stored.
- Sits between the host/UART byte source and the instruction memory; the CPU fetch path is untouched.

Parameters:
- SIZE, 64, instruction memory depth in words.
- DATA_WIDTH, 32, instruction width; fixed at 32, 4 bytes per word.
- HALT_WORD, 32'hB4221820, encoding that terminates every program.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a load.
- rx_valid  input  1  byte source has data.
- rx_data  input  8  program byte.
- rx_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction memory write strobe, one cycle per word.
- wr_addr  output  32  byte address of the word, always word index*4.
- wr_data  output  32  assembled instruction.
- cpu_hold  output  1  keep the CPU in reset while high.
- done  output  1  program loaded, HALT stored.
- overflow_err  output  1  SIZE words written without a HALT.
- word_count  output  $clog2(SIZE)+1  number of words written in the current load.

Behaviour:
- Reset (reset low, asynchronous) sets: state=IDLE, rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, overflow_err=0, word_count=0, byte counter=0.
- Reset mid-load abandons any partial word with no write. Memory contents already written are not erased.
- States are IDLE, LOAD, WRITE, DONE, ERROR.
- IDLE:
  - rx_ready=0; cpu_hold=1.
  - start -> LOAD; clears word_count, byte counter, done, overflow_err.
- LOAD:
  - rx_ready=1.
  - Each cycle with rx_valid && rx_ready is one byte transfer. Byte k (0..3) goes to wr_data bits [31-8k -: 8], first byte MSB.
  - The 4th transfer -> WRITE.
  - Gaps in rx_valid are legal and preserve the partial word.
- WRITE:
  - Exactly one cycle with wr_en=1, wr_addr=word_count*4, wr_data=assembled word, rx_ready=0.
  - word_count increments at the end of the cycle.
  - Next state:
    - If wr_data==HALT_WORD -> DONE. HALT is checked first, so a HALT in the last slot succeeds.
    - Else if the incremented word_count==SIZE -> ERROR.
    - Else -> LOAD.
  - Peak throughput is 4 bytes per 5 cycles.
- DONE:
  - done=1, cpu_hold=0, rx_ready=0.
  - start -> LOAD, re-asserting cpu_hold in the same cycle the state changes.
- ERROR:
  - overflow_err=1, cpu_hold=1, rx_ready=0.
  - start -> LOAD as in DONE.
- start is ignored in LOAD and WRITE.
- rx_valid is ignored outside LOAD; bytes are not consumed.
- wr_addr and wr_data hold their last values when wr_en=0; wr_en is never asserted outside WRITE.
- Data is only written when all 4 bytes of a word have arrived.

Decomposition:
- Shared package imem_pkg holds:
  - HALT_WORD constant;
  - loader state typedef (IDLE/LOAD/WRITE/DONE/ERROR);
  - BYTES_PER_WORD=4;
  - the word-to-byte-address shift (2), shared with the fetch side's address>>2 indexing.
- One sub-module: byte_packer. It takes a byte strobe and data plus a clear, and produces a 2-bit lane counter, the 32-bit word and a word_full pulse.
- The FSM, address counter and status flags stay in imem_loader.

Test Plan:
- 3-word load: start, then bytes 8C 01 00 00 34 02 00 04 B4 22 18 20 back-to-back. Expect wr_en pulses at addresses 0/4/8 with data 8C010000/34020004/B4221820, then done=1, cpu_hold=0, word_count=3.
- Gapped source: same stream with rx_valid low 3 cycles between every byte. Expect identical writes, and no write before the 4th byte of each word.
- Overflow, SIZE=4: four non-HALT words 00000020. Expect 4 writes at 0..12, then overflow_err=1, cpu_hold=1, done=0. Variant with HALT as the 4th word gives done=1.
- Reset mid-word: after 2 bytes 8C 01, pulse reset low. Expect no wr_en, state IDLE, cpu_hold=1, word_count=0. A fresh start plus 8C 01 00 00 writes 8C010000 to address 0.
- Control misuse:
  - rx_valid=1 in IDLE: expect rx_ready=0 and no capture.
  - start pulse mid-LOAD: no effect on counters.
  - start in DONE: reloads a new 2-word program (00000020, B4221820) to addresses 0/4, with cpu_hold=1 throughout the reload.
